// File: rtl/conv_stream_engine.sv
// Streaming k x k 2-D convolver with a serially loaded kernel and bias.
// Activations arrive row-major through a valid/ready handshake. A shift-register
// line buffer keeps the last (k-1)*n + k pixels, so every tap of the window that
// ends at the newest pixel sits at a fixed offset. Results pass through a
// two-stage MAC/rescale pipeline and saturate to N bits.
module conv_stream_engine #(
    parameter int n = 10,
    parameter int k = 3,
    parameter int s = 1,
    parameter int N = 16,
    parameter int Q = 12
) (
    input  logic         clk,
    input  logic         global_rst_n,
    input  logic         ce,
    input  logic         wt_load,
    input  logic [N-1:0] wt_data,
    input  logic         act_valid,
    output logic         act_ready,
    input  logic [N-1:0] activation,
    output logic [N-1:0] conv_op,
    output logic         valid_conv,
    output logic         end_conv
);
    localparam int KK     = k * k;
    localparam int LB_LEN = (k - 1) * n + k;
    localparam int ACC_W  = 2 * N + $clog2(KK);
    localparam int SUM_W  = ACC_W + 1;
    localparam int RC_W   = $clog2(n);
    localparam int PIX_W  = $clog2(n * n);
    localparam int LD_W   = $clog2(KK + 1);
    localparam int PH_W   = (s > 1) ? $clog2(s) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Clamp a widened sum to the signed N-bit range
    function automatic logic [N-1:0] sat_n(input logic [SUM_W-1:0] x);
        logic [SUM_W-N:0] hi;
        hi = x[SUM_W-1:N-1];
        if ((&hi) || !(|hi)) begin
            return x[N-1:0];
        end else if (x[SUM_W-1]) begin
            return {1'b1, {(N-1){1'b0}}};
        end else begin
            return {1'b0, {(N-1){1'b1}}};
        end
    endfunction

    state_e             state_q, state_d;
    logic [LD_W-1:0]    ld_cnt_q, ld_cnt_d;
    logic               wt_ready_q, wt_ready_d;
    logic               flush_cnt_q, flush_cnt_d;
    logic [N-1:0]       w_q [0:KK-1];
    logic [N-1:0]       w_d [0:KK-1];
    logic [N-1:0]       bias_q, bias_d;
    logic               act_ready_q, act_ready_d;
    logic               end_conv_q, end_conv_d;

    logic [RC_W-1:0]    col_q, col_d, row_q, row_d;
    logic [PH_W-1:0]    col_ph_q, col_ph_d, row_ph_q, row_ph_d;
    logic [PIX_W-1:0]   pix_q, pix_d;
    logic [N-1:0]       lb_q [0:LB_LEN-1];
    logic [N-1:0]       lb_d [0:LB_LEN-1];
    logic               win_done_q, win_done_d;

    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               acc_vld_q, acc_vld_d;
    logic [N-1:0]       conv_op_q, conv_op_d;
    logic               valid_conv_q, valid_conv_d;

    logic               acc_s;
    logic               last_pix_s;
    logic [2*N-1:0]     prod_s;
    logic [ACC_W-1:0]   acc_sum_s;
    logic [ACC_W-1:0]   shifted_s;
    logic [SUM_W-1:0]   sum_s;

    // A pending weight word in IDLE takes priority over an activation
    assign acc_s      = act_valid & act_ready_q & ce & ~(wt_load & (state_q == IDLE));
    assign last_pix_s = (pix_q == PIX_W'(n * n - 1));

    assign act_ready  = act_ready_q;
    assign end_conv   = end_conv_q;
    assign valid_conv = valid_conv_q;
    assign conv_op    = conv_op_q;

    // FSM next state, serial weight/bias capture and end-of-frame pulse
    always_comb begin
        state_d     = state_q;
        ld_cnt_d    = ld_cnt_q;
        wt_ready_d  = wt_ready_q;
        flush_cnt_d = flush_cnt_q;
        bias_d      = bias_q;
        end_conv_d  = end_conv_q;
        for (int j = 0; j < KK; j++) begin
            w_d[j] = w_q[j];
        end
        if (ce) begin
            end_conv_d = (state_q == DONE);
            case (state_q)
                IDLE: begin
                    if (wt_load) begin
                        state_d    = LOAD;
                        wt_ready_d = 1'b0;
                        w_d[0]     = wt_data;
                        ld_cnt_d   = LD_W'(1);
                    end else if (acc_s) begin
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                LOAD: begin
                    if (wt_load) begin
                        if (ld_cnt_q == LD_W'(KK)) begin
                            bias_d     = wt_data;
                            ld_cnt_d   = {LD_W{1'b0}};
                            wt_ready_d = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            for (int j = 0; j < KK; j++) begin
                                if (ld_cnt_q == LD_W'(j)) begin
                                    w_d[j] = wt_data;
                                end else begin
                                    w_d[j] = w_q[j];
                                end
                            end
                            ld_cnt_d = ld_cnt_q + LD_W'(1);
                        end
                    end else begin
                        state_d = LOAD;
                    end
                end
                RUN: begin
                    if (acc_s && last_pix_s) begin
                        state_d     = FLUSH;
                        flush_cnt_d = 1'b0;
                    end else begin
                        state_d = RUN;
                    end
                end
                FLUSH: begin
                    if (flush_cnt_q) begin
                        state_d     = DONE;
                        flush_cnt_d = 1'b0;
                    end else begin
                        flush_cnt_d = 1'b1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else begin
            end_conv_d = end_conv_q;
        end
        act_ready_d = wt_ready_d & ((state_d == IDLE) || (state_d == RUN));
    end

    // Pixel/row/col counters, stride phases, line-buffer shift and window-completion flag
    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        col_ph_d   = col_ph_q;
        row_ph_d   = row_ph_q;
        pix_d      = pix_q;
        win_done_d = win_done_q;
        for (int i = 0; i < LB_LEN; i++) begin
            lb_d[i] = lb_q[i];
        end
        if (acc_s) begin
            lb_d[0] = activation;
            for (int i = 1; i < LB_LEN; i++) begin
                lb_d[i] = lb_q[i-1];
            end
            win_done_d = (row_q >= RC_W'(k - 1)) && (col_q >= RC_W'(k - 1)) &&
                         (row_ph_q == {PH_W{1'b0}}) && (col_ph_q == {PH_W{1'b0}});
            pix_d = last_pix_s ? {PIX_W{1'b0}} : pix_q + PIX_W'(1);
            if (col_q == RC_W'(n - 1)) begin
                col_d    = {RC_W{1'b0}};
                col_ph_d = {PH_W{1'b0}};
                if (row_q == RC_W'(n - 1)) begin
                    row_d    = {RC_W{1'b0}};
                    row_ph_d = {PH_W{1'b0}};
                end else begin
                    row_d = row_q + RC_W'(1);
                    if (row_q + RC_W'(1) == RC_W'(k - 1)) begin
                        row_ph_d = {PH_W{1'b0}};
                    end else if (row_q >= RC_W'(k - 1)) begin
                        row_ph_d = (row_ph_q == PH_W'(s - 1)) ? {PH_W{1'b0}} : row_ph_q + PH_W'(1);
                    end else begin
                        row_ph_d = {PH_W{1'b0}};
                    end
                end
            end else begin
                col_d = col_q + RC_W'(1);
                if (col_q + RC_W'(1) == RC_W'(k - 1)) begin
                    col_ph_d = {PH_W{1'b0}};
                end else if (col_q >= RC_W'(k - 1)) begin
                    col_ph_d = (col_ph_q == PH_W'(s - 1)) ? {PH_W{1'b0}} : col_ph_q + PH_W'(1);
                end else begin
                    col_ph_d = {PH_W{1'b0}};
                end
            end
        end else if (ce) begin
            win_done_d = 1'b0;
        end else begin
            win_done_d = win_done_q;
        end
    end

    // Full-precision multiply-accumulate over the window completed on the previous accept
    always_comb begin
        acc_sum_s = {ACC_W{1'b0}};
        prod_s    = {(2*N){1'b0}};
        for (int r = 0; r < k; r++) begin
            for (int c = 0; c < k; c++) begin
                prod_s = $signed({{N{lb_q[(k-1-r)*n + (k-1-c)][N-1]}}, lb_q[(k-1-r)*n + (k-1-c)]}) *
                         $signed({{N{w_q[r*k + c][N-1]}}, w_q[r*k + c]});
                acc_sum_s = acc_sum_s + {{(ACC_W-2*N){prod_s[2*N-1]}}, prod_s};
            end
        end
        if (ce && win_done_q) begin
            acc_d = acc_sum_s;
        end else begin
            acc_d = acc_q;
        end
        if (ce) begin
            acc_vld_d = win_done_q;
        end else begin
            acc_vld_d = acc_vld_q;
        end
    end

    // Rescale by 2^-Q (floor), add bias, saturate and register the result pulse
    always_comb begin
        shifted_s = $signed(acc_q) >>> Q;
        sum_s     = {shifted_s[ACC_W-1], shifted_s} + {{(SUM_W-N){bias_q[N-1]}}, bias_q};
        if (ce) begin
            valid_conv_d = acc_vld_q;
            if (acc_vld_q) begin
                conv_op_d = sat_n(sum_s);
            end else begin
                conv_op_d = conv_op_q;
            end
        end else begin
            valid_conv_d = valid_conv_q;
            conv_op_d    = conv_op_q;
        end
    end

    // All state registers; reset wins over ce and abandons any frame in progress
    always_ff @(posedge clk) begin
        if (!global_rst_n) begin
            state_q      <= IDLE;
            ld_cnt_q     <= {LD_W{1'b0}};
            wt_ready_q   <= 1'b0;
            flush_cnt_q  <= 1'b0;
            bias_q       <= {N{1'b0}};
            act_ready_q  <= 1'b0;
            end_conv_q   <= 1'b0;
            col_q        <= {RC_W{1'b0}};
            row_q        <= {RC_W{1'b0}};
            col_ph_q     <= {PH_W{1'b0}};
            row_ph_q     <= {PH_W{1'b0}};
            pix_q        <= {PIX_W{1'b0}};
            win_done_q   <= 1'b0;
            acc_q        <= {ACC_W{1'b0}};
            acc_vld_q    <= 1'b0;
            conv_op_q    <= {N{1'b0}};
            valid_conv_q <= 1'b0;
            for (int j = 0; j < KK; j++) begin
                w_q[j] <= {N{1'b0}};
            end
            for (int i = 0; i < LB_LEN; i++) begin
                lb_q[i] <= {N{1'b0}};
            end
        end else begin
            state_q      <= state_d;
            ld_cnt_q     <= ld_cnt_d;
            wt_ready_q   <= wt_ready_d;
            flush_cnt_q  <= flush_cnt_d;
            bias_q       <= bias_d;
            act_ready_q  <= act_ready_d;
            end_conv_q   <= end_conv_d;
            col_q        <= col_d;
            row_q        <= row_d;
            col_ph_q     <= col_ph_d;
            row_ph_q     <= row_ph_d;
            pix_q        <= pix_d;
            win_done_q   <= win_done_d;
            acc_q        <= acc_d;
            acc_vld_q    <= acc_vld_d;
            conv_op_q    <= conv_op_d;
            valid_conv_q <= valid_conv_d;
            for (int j = 0; j < KK; j++) begin
                w_q[j] <= w_d[j];
            end
            for (int i = 0; i < LB_LEN; i++) begin
                lb_q[i] <= lb_d[i];
            end
        end
    end

endmodule

// File: tb/tb_conv_stream_engine.sv
// Bench for conv_stream_engine: two instances (stride 1 and stride 2) share one
// stimulus stream; each is checked against a window-level reference model.
module tb_conv_stream_engine;
    localparam int NN = 10;
    localparam int K  = 3;
    localparam int QF = 12;
    localparam int NP = NN * NN;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic        wt_load;
    logic [15:0] wt_data;
    logic        act_valid;
    logic [15:0] activation;
    logic        rdy1, rdy2, vc1, vc2, ec1, ec2;
    logic [15:0] op1, op2;

    int n_cmp = 0;
    int n_err = 0;

    int w_tb [K*K];
    int bias_tb;
    int pix_tb [NP];
    logic [15:0] exp_q1 [$];
    logic [15:0] exp_q2 [$];

    always #5 clk = ~clk;

    conv_stream_engine #(.n(NN), .k(K), .s(1), .N(16), .Q(QF)) u_dut1 (
        .clk(clk), .global_rst_n(rst_n), .ce(ce), .wt_load(wt_load), .wt_data(wt_data),
        .act_valid(act_valid), .act_ready(rdy1), .activation(activation),
        .conv_op(op1), .valid_conv(vc1), .end_conv(ec1)
    );

    conv_stream_engine #(.n(NN), .k(K), .s(2), .N(16), .Q(QF)) u_dut2 (
        .clk(clk), .global_rst_n(rst_n), .ce(ce), .wt_load(wt_load), .wt_data(wt_data),
        .act_valid(act_valid), .act_ready(rdy2), .activation(activation),
        .conv_op(op2), .valid_conv(vc2), .end_conv(ec2)
    );

    // Reference: one window result straight from the arithmetic definition
    function automatic logic [15:0] model_out(input int r0, input int c0);
        longint acc = 0;
        longint res;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                acc += longint'(w_tb[r*K + c]) * longint'(pix_tb[(r0 + r)*NN + c0 + c]);
            end
        end
        res = (acc >>> QF) + longint'(bias_tb);
        if (res > 64'sd32767) res = 64'sd32767;
        else if (res < -64'sd32768) res = -64'sd32768;
        return 16'(res);
    endfunction

    // Does accepting pixel p complete a valid window at stride st?
    function automatic bit completes(input int p, input int st);
        int rr, cc;
        rr = p / NN - (K - 1);
        cc = p % NN - (K - 1);
        return (rr >= 0) && (cc >= 0) && (rr % st == 0) && (cc % st == 0);
    endfunction

    task automatic load_weights();
        for (int j = 0; j <= K*K; j++) begin
            ce = 1'b1; wt_load = 1'b1; act_valid = 1'b0;
            wt_data = (j < K*K) ? 16'(w_tb[j]) : 16'(bias_tb);
            @(posedge clk); #1;
            if (j == 0) begin
                n_cmp++;
                if (rdy1 !== 1'b0 || rdy2 !== 1'b0) begin
                    n_err++; $display("FAIL load_ready_low: got %b/%b want 0", rdy1, rdy2);
                end
            end
        end
        wt_load = 1'b0;
        n_cmp++;
        if (rdy1 !== 1'b1 || rdy2 !== 1'b1) begin
            n_err++; $display("FAIL load_ready_high: got %b/%b want 1", rdy1, rdy2);
        end
    endtask

    // Stream one frame (or its first stop_after pixels) and check every ce-cycle
    task automatic run_frame(input string tag, input bit gaps, input int stop_after);
        int h0, h1, h2, h3, sent, drain, cycles, nv1, nv2, ne1, ne2;
        bit rdy_now, exp_v1, exp_v2, exp_e, exp_r;
        logic [15:0] prev1, prev2, ev;
        exp_q1.delete(); exp_q2.delete();
        for (int r = 0; r + K <= NN; r++)
            for (int c = 0; c + K <= NN; c++) exp_q1.push_back(model_out(r, c));
        for (int r = 0; r + K <= NN; r += 2)
            for (int c = 0; c + K <= NN; c += 2) exp_q2.push_back(model_out(r, c));
        h0 = -1; h1 = -1; h2 = -1; h3 = -1;
        sent = 0; drain = 0; cycles = 0; nv1 = 0; nv2 = 0; ne1 = 0; ne2 = 0;
        while (1) begin
            if (stop_after < NP && sent >= stop_after) break;
            if (sent >= NP && drain >= 6) break;
            if (cycles >= 4000) begin
                n_cmp++; n_err++;
                $display("FAIL %s_timeout: sent %0d want %0d", tag, sent, stop_after);
                break;
            end
            ce = gaps ? ($urandom_range(0, 99) >= 30) : 1'b1;
            act_valid = (sent < stop_after) && (gaps ? ($urandom_range(0, 99) >= 40) : 1'b1);
            activation = (act_valid && sent < NP) ? 16'(pix_tb[sent]) : 16'($urandom);
            rdy_now = rdy1;
            prev1 = op1; prev2 = op2;
            @(posedge clk); #1;
            cycles++;
            if (!ce) begin
                n_cmp++;
                if (op1 !== prev1 || op2 !== prev2) begin
                    n_err++; $display("FAIL %s_hold: got %h/%h want %h/%h", tag, op1, op2, prev1, prev2);
                end
                continue;
            end
            h3 = h2; h2 = h1; h1 = h0;
            if (act_valid && rdy_now) begin h0 = sent; sent++; end
            else h0 = -1;
            if (sent >= NP) drain++;
            exp_v1 = (h2 >= 0) && completes(h2, 1);
            exp_v2 = (h2 >= 0) && completes(h2, 2);
            exp_e  = (h3 == NP - 1);
            exp_r  = !((h0 == NP - 1) || (h1 == NP - 1) || (h2 == NP - 1));
            n_cmp++;
            if (vc1 !== exp_v1 || vc2 !== exp_v2) begin
                n_err++; $display("FAIL %s_valid: got %b/%b want %b/%b (pix %0d)", tag, vc1, vc2, exp_v1, exp_v2, h2);
            end
            n_cmp++;
            if (ec1 !== exp_e || ec2 !== exp_e) begin
                n_err++; $display("FAIL %s_end: got %b/%b want %b", tag, ec1, ec2, exp_e);
            end
            n_cmp++;
            if (rdy1 !== exp_r || rdy2 !== exp_r) begin
                n_err++; $display("FAIL %s_ready: got %b/%b want %b", tag, rdy1, rdy2, exp_r);
            end
            if (vc1 === 1'b1) nv1++;
            if (vc2 === 1'b1) nv2++;
            if (ec1 === 1'b1) ne1++;
            if (ec2 === 1'b1) ne2++;
            if (exp_v1 && exp_q1.size() > 0) begin
                ev = exp_q1.pop_front();
                n_cmp++;
                if (op1 !== ev) begin
                    n_err++; $display("FAIL %s_op_s1: got %h want %h (pix %0d)", tag, op1, ev, h2);
                end
            end
            if (exp_v2 && exp_q2.size() > 0) begin
                ev = exp_q2.pop_front();
                n_cmp++;
                if (op2 !== ev) begin
                    n_err++; $display("FAIL %s_op_s2: got %h want %h (pix %0d)", tag, op2, ev, h2);
                end
            end
        end
        act_valid = 1'b0; ce = 1'b1;
        if (stop_after >= NP) begin
            n_cmp++;
            if (nv1 != ((NN - K) / 1 + 1) ** 2 || nv2 != ((NN - K) / 2 + 1) ** 2) begin
                n_err++; $display("FAIL %s_count: got %0d/%0d want %0d/%0d", tag, nv1, nv2,
                                  ((NN - K) / 1 + 1) ** 2, ((NN - K) / 2 + 1) ** 2);
            end
            n_cmp++;
            if (ne1 != 1 || ne2 != 1) begin
                n_err++; $display("FAIL %s_end_count: got %0d/%0d want 1", tag, ne1, ne2);
            end
        end
    endtask

    task automatic set_identity(input int b);
        for (int j = 0; j < K*K; j++) w_tb[j] = 0;
        w_tb[4] = 32'h1000;
        bias_tb = b;
        for (int p = 0; p < NP; p++) pix_tb[p] = p;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ce = 1'b0; wt_load = 1'b0; wt_data = 16'h0000;
        act_valid = 1'b0; activation = 16'h0000;
        @(posedge clk); #1;
        ce = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            act_valid = 1'b1; activation = 16'($urandom);
            @(posedge clk); #1;
            n_cmp++;
            if (rdy1 !== 1'b0 || rdy2 !== 1'b0 || vc1 !== 1'b0 || vc2 !== 1'b0 ||
                ec1 !== 1'b0 || ec2 !== 1'b0 || op1 !== 16'h0000 || op2 !== 16'h0000) begin
                n_err++;
                $display("FAIL reset_outputs: got rdy %b%b vc %b%b end %b%b op %h/%h want all 0",
                         rdy1, rdy2, vc1, vc2, ec1, ec2, op1, op2);
            end
        end
        act_valid = 1'b0;
    endtask

    task automatic test_identity();
        set_identity(0);
        load_weights();
        run_frame("identity", 1'b0, NP);
    endtask

    task automatic test_stride_bias();
        set_identity(5);
        load_weights();
        run_frame("stride_bias", 1'b0, NP);
    endtask

    task automatic test_saturation();
        for (int j = 0; j < K*K; j++) w_tb[j] = 32767;
        bias_tb = 32767;
        for (int p = 0; p < NP; p++) pix_tb[p] = 32767;
        load_weights();
        run_frame("sat_pos", 1'b0, NP);
        for (int j = 0; j < K*K; j++) w_tb[j] = -32768;
        bias_tb = 0;
        load_weights();
        run_frame("sat_neg", 1'b0, NP);
    endtask

    task automatic test_gaps();
        set_identity(0);
        load_weights();
        run_frame("gaps", 1'b1, NP);
    endtask

    task automatic test_random();
        for (int f = 0; f < 2; f++) begin
            for (int j = 0; j < K*K; j++) w_tb[j] = int'($urandom_range(0, 8191)) - 4096;
            bias_tb = int'($urandom_range(0, 65535)) - 32768;
            for (int p = 0; p < NP; p++) pix_tb[p] = int'($urandom_range(0, 65535)) - 32768;
            load_weights();
            run_frame("random", 1'b1, NP);
        end
    endtask

    task automatic test_reset_reload();
        set_identity(0);
        load_weights();
        run_frame("pre_reset", 1'b0, 51);
        rst_n = 1'b0; ce = 1'b0; act_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (rdy1 !== 1'b0 || rdy2 !== 1'b0 || vc1 !== 1'b0 || vc2 !== 1'b0 ||
            ec1 !== 1'b0 || ec2 !== 1'b0 || op1 !== 16'h0000 || op2 !== 16'h0000) begin
            n_err++;
            $display("FAIL midframe_reset: got rdy %b%b vc %b%b end %b%b op %h/%h want all 0",
                     rdy1, rdy2, vc1, vc2, ec1, ec2, op1, op2);
        end
        rst_n = 1'b1; ce = 1'b1; act_valid = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (rdy1 !== 1'b0 || rdy2 !== 1'b0) begin
            n_err++; $display("FAIL reset_needs_reload: got %b/%b want 0", rdy1, rdy2);
        end
        act_valid = 1'b0;
        load_weights();
        run_frame("reload", 1'b0, NP);
    endtask

    initial begin
        test_reset();
        test_identity();
        test_stride_bias();
        test_saturation();
        test_gaps();
        test_random();
        test_reset_reload();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
